// File: rtl/simd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : simd_sequencer_if
// Description : Handshake and control bundle between the SIMD control
//               sequencer, the instruction fetch unit, the data fetch
//               (load/store) unit and the PE array.
//               master : sequencer side (takes instruction and done inputs,
//                        drives the phase controls)
//               slave  : surrounding units / environment side
// Signals     : INSTR, START_SIGNAL, FETCH_DONE, STORE_DONE, MAC_DONE (in to
//               sequencer); PC_INCR, INSTR_DONE, DIMEN, ADDR_START, ADDR_RST,
//               WRADDR_START, ADDRESS, WRITE_MAT, MAT_MUX, MAC_CTRL, RST_ACC,
//               RST_PC, RST_ADD, OUT_READY, STOP_SIGNAL, ERR_SIGNAL,
//               INSTR_COUNT (out of sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
interface simd_sequencer_if #(
  parameter int NUM_PE = 4,
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
);
  logic [31:0]       INSTR;
  logic              START_SIGNAL;
  logic              FETCH_DONE;
  logic              STORE_DONE;
  logic [NUM_PE-1:0] MAC_DONE;

  logic              PC_INCR;
  logic              INSTR_DONE;
  logic [1:0]        DIMEN;
  logic              ADDR_START;
  logic              ADDR_RST;
  logic              WRADDR_START;
  logic [ADDR_W-1:0] ADDRESS;
  logic [NUM_PE-1:0] WRITE_MAT;
  logic [NUM_PE-1:0] MAT_MUX;
  logic [NUM_PE-1:0] MAC_CTRL;
  logic [NUM_PE-1:0] RST_ACC;
  logic [NUM_PE-1:0] RST_PC;
  logic [NUM_PE-1:0] RST_ADD;
  logic [NUM_PE-1:0] OUT_READY;
  logic              STOP_SIGNAL;
  logic              ERR_SIGNAL;
  logic [CNT_W-1:0]  INSTR_COUNT;

  modport master (
    input  INSTR, START_SIGNAL, FETCH_DONE, STORE_DONE, MAC_DONE,
    output PC_INCR, INSTR_DONE, DIMEN, ADDR_START, ADDR_RST, WRADDR_START,
           ADDRESS, WRITE_MAT, MAT_MUX, MAC_CTRL, RST_ACC, RST_PC, RST_ADD,
           OUT_READY, STOP_SIGNAL, ERR_SIGNAL, INSTR_COUNT
  );

  modport slave (
    output INSTR, START_SIGNAL, FETCH_DONE, STORE_DONE, MAC_DONE,
    input  PC_INCR, INSTR_DONE, DIMEN, ADDR_START, ADDR_RST, WRADDR_START,
           ADDRESS, WRITE_MAT, MAT_MUX, MAC_CTRL, RST_ACC, RST_PC, RST_ADD,
           OUT_READY, STOP_SIGNAL, ERR_SIGNAL, INSTR_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/simd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : simd_sequencer
// Description : Parametrised SIMD control sequencer. Decodes 32-bit
//               instructions and sequences load, multiply-accumulate and
//               store phases across NUM_PE processing elements, with PE
//               select masks, illegal-instruction trap and a saturating
//               retired-instruction counter.
//               Optional macro SEQ_WATCHDOG_EN: phase watchdog that forces
//               the ERROR state after TIMEOUT cycles in one phase.
// Ports       : CLK  - clock
//               RSTN - asynchronous reset, active high
//               bus  - simd_sequencer_if.master (instruction, done inputs,
//                      all phase/PE controls and status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module simd_sequencer #(
  parameter int NUM_PE  = 4,
  parameter int ADDR_W  = 17,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RSTN,
  simd_sequencer_if.master bus
);

  // State codes 0..6 equal the opcodes, so a legal opcode casts directly.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOADA   = 3'd2,
    S_LOADB   = 3'd3,
    S_MULTACC = 3'd4,
    S_STORE   = 3'd5,
    S_STOP    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam logic [2:0]        c_OP_STOP    = 3'd6;
  localparam logic [2:0]        c_OP_ILLEGAL = 3'd7;
  localparam logic [6:0]        c_NUM_PE7    = 7'(NUM_PE);
  localparam logic [NUM_PE-1:0] c_ONE        = NUM_PE'(1);

  state_t              state_q;
  logic [NUM_PE-1:0]   pe_mask_q;
  logic [ADDR_W-1:0]   ins_addr_q;
  logic [1:0]          ins_dimen_q;

  logic                pc_incr_q;
  logic [1:0]          dimen_q;
  logic                addr_start_q;
  logic                addr_rst_q;
  logic                wraddr_start_q;
  logic [ADDR_W-1:0]   address_q;
  logic [NUM_PE-1:0]   write_mat_q;
  logic [NUM_PE-1:0]   mat_mux_q;
  logic [NUM_PE-1:0]   mac_ctrl_q;
  logic [NUM_PE-1:0]   rst_acc_q;
  logic [NUM_PE-1:0]   rst_pc_q;
  logic [NUM_PE-1:0]   rst_add_q;
  logic [NUM_PE-1:0]   out_ready_q;
  logic                stop_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  // Instruction field decode
  logic [2:0]          w_opcode;
  logic [1:0]          w_mode;
  logic [5:0]          w_idx;
  logic                w_sel;
  logic                w_idx_ok;
  logic                w_illegal;
  logic [NUM_PE-1:0]   mask_d;
  logic                w_mac_done;
  logic                w_instr_done;
  logic                w_wd_expired;

  assign w_opcode = bus.INSTR[2:0];
  assign w_mode   = bus.INSTR[8:7];
  assign w_idx    = bus.INSTR[14:9];
  assign w_sel    = bus.INSTR[13];

  always_comb begin
    mask_d   = '1;
    w_idx_ok = 1'b1;
    case (w_mode)
      2'd0: mask_d = '1;
      2'd1: begin
        mask_d   = c_ONE << w_idx;
        w_idx_ok = ({1'b0, w_idx} < c_NUM_PE7);
      end
      2'd2: begin
        for (int i = 0; i < NUM_PE; i++)
          mask_d[i] = w_sel ? (i < NUM_PE / 2) : (i >= NUM_PE / 2);
      end
      default: begin
        for (int i = 0; i < NUM_PE; i++)
          mask_d[i] = w_sel ? (i % 2 == 0) : (i % 2 == 1);
      end
    endcase
  end

  assign w_illegal  = (w_opcode == c_OP_ILLEGAL) || !w_idx_ok;

  // Only PEs selected by the latched mask take part in the reduction.
  assign w_mac_done = ((bus.MAC_DONE & pe_mask_q) == pe_mask_q);

  assign w_instr_done = ((state_q == S_IDLE) && bus.START_SIGNAL) ||
                        (((state_q == S_LOADA) || (state_q == S_LOADB)) && bus.FETCH_DONE) ||
                        ((state_q == S_MULTACC) && w_mac_done) ||
                        ((state_q == S_STORE) && bus.STORE_DONE);

`ifdef SEQ_WATCHDOG_EN
  localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [c_WD_W-1:0] wd_q;
  logic              w_in_phase;

  assign w_in_phase = (state_q == S_LOADA) || (state_q == S_LOADB) ||
                      (state_q == S_MULTACC) || (state_q == S_STORE);

  // wd_q counts completed cycles in the current phase; a phase that is
  // still waiting on its TIMEOUT-th cycle is aborted.
  assign w_wd_expired = w_in_phase && (wd_q == c_WD_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN)
      wd_q <= '0;
    else if (w_in_phase && !w_instr_done && !w_wd_expired)
      wd_q <= wd_q + 1'b1;
    else
      wd_q <= '0;
  end

  logic w_unused;
  assign w_unused = &{1'b0, bus.INSTR};
`else
  assign w_wd_expired = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, bus.INSTR, (TIMEOUT > 0)};
`endif

  // Outputs are registered from the current state, so each one appears
  // the cycle after the state that asserts it.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state_q        <= S_IDLE;
      pe_mask_q      <= '0;
      ins_addr_q     <= '0;
      ins_dimen_q    <= '0;
      pc_incr_q      <= 1'b0;
      dimen_q        <= '0;
      addr_start_q   <= 1'b0;
      addr_rst_q     <= 1'b1;
      wraddr_start_q <= 1'b0;
      address_q      <= '0;
      write_mat_q    <= '0;
      mat_mux_q      <= '0;
      mac_ctrl_q     <= '0;
      rst_acc_q      <= '1;
      rst_pc_q       <= '1;
      rst_add_q      <= '1;
      out_ready_q    <= '0;
      stop_q         <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      pc_incr_q      <= 1'b0;
      dimen_q        <= '0;
      addr_start_q   <= 1'b0;
      addr_rst_q     <= 1'b0;
      wraddr_start_q <= 1'b0;
      address_q      <= '0;
      write_mat_q    <= '0;
      mat_mux_q      <= '0;
      mac_ctrl_q     <= '0;
      rst_acc_q      <= '0;
      rst_pc_q       <= '0;
      rst_add_q      <= '0;
      out_ready_q    <= '0;

      // The IDLE start handshake is not a retired instruction.
      if (w_instr_done && (state_q != S_IDLE) && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.START_SIGNAL)
            state_q <= S_FETCH;
        end

        S_FETCH: begin
          pc_incr_q   <= 1'b1;
          dimen_q     <= bus.INSTR[4:3];
          rst_acc_q   <= {NUM_PE{bus.INSTR[5]}};
          pe_mask_q   <= mask_d;
          ins_addr_q  <= bus.INSTR[31 -: ADDR_W];
          ins_dimen_q <= bus.INSTR[4:3];
          if (w_illegal) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            stop_q  <= 1'b1;
          end else begin
            state_q <= state_t'(w_opcode);
            if (w_opcode == c_OP_STOP)
              stop_q <= 1'b1;
          end
        end

        S_LOADA, S_LOADB: begin
          if (bus.FETCH_DONE) begin
            addr_rst_q <= 1'b1;
            rst_add_q  <= '1;
            state_q    <= S_FETCH;
          end else if (w_wd_expired) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            stop_q  <= 1'b1;
          end else begin
            write_mat_q  <= pe_mask_q;
            mat_mux_q    <= {NUM_PE{state_q == S_LOADA}};
            address_q    <= ins_addr_q;
            dimen_q      <= ins_dimen_q;
            addr_start_q <= 1'b1;
          end
        end

        S_MULTACC: begin
          if (w_mac_done) begin
            rst_pc_q <= pe_mask_q;
            state_q  <= S_FETCH;
          end else if (w_wd_expired) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            stop_q  <= 1'b1;
          end else begin
            mac_ctrl_q <= pe_mask_q;
          end
        end

        S_STORE: begin
          if (bus.STORE_DONE) begin
            addr_rst_q <= 1'b1;
            state_q    <= S_FETCH;
          end else if (w_wd_expired) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            stop_q  <= 1'b1;
          end else begin
            out_ready_q    <= '1;
            wraddr_start_q <= 1'b1;
            address_q      <= ins_addr_q;
            addr_start_q   <= 1'b1;
          end
        end

        S_STOP: begin
          stop_q <= 1'b1;
        end

        default: begin
          err_q  <= 1'b1;
          stop_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.INSTR_DONE   = w_instr_done;
  assign bus.PC_INCR      = pc_incr_q;
  assign bus.DIMEN        = dimen_q;
  assign bus.ADDR_START   = addr_start_q;
  assign bus.ADDR_RST     = addr_rst_q;
  assign bus.WRADDR_START = wraddr_start_q;
  assign bus.ADDRESS      = address_q;
  assign bus.WRITE_MAT    = write_mat_q;
  assign bus.MAT_MUX      = mat_mux_q;
  assign bus.MAC_CTRL     = mac_ctrl_q;
  assign bus.RST_ACC      = rst_acc_q;
  assign bus.RST_PC       = rst_pc_q;
  assign bus.RST_ADD      = rst_add_q;
  assign bus.OUT_READY    = out_ready_q;
  assign bus.STOP_SIGNAL  = stop_q;
  assign bus.ERR_SIGNAL   = err_q;
  assign bus.INSTR_COUNT  = cnt_q;

endmodule
`default_nettype wire
